// File: rtl/x74194_shift.sv
// Universal shift register in the style of a 74194, generalised to WIDTH bits.
// Runs on the system clock; the TTL clock is edge-detected or used as an enable.
module x74194_shift #(
    parameter int               WIDTH       = 4,
    parameter bit               EDGE_DETECT = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ttl_clk,
    input  logic             clr_n,
    input  logic [1:0]       s,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sro,
    output logic             slo,
    output logic             adv
);

    logic [WIDTH-1:0] q_reg;
    logic             ttl_clk_d;
    logic             adv_i;

    generate
        if (EDGE_DETECT) begin : g_edge
            assign adv_i = ttl_clk & ~ttl_clk_d;
        end else begin : g_level
            assign adv_i = ttl_clk;
        end
    endgenerate

    // ttl_clk_d resets high so a TTL clock held high through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg     <= RESET_VAL;
            ttl_clk_d <= 1'b1;
        end else begin
            ttl_clk_d <= ttl_clk;
            if (!clr_n) begin
                q_reg <= '0;
            end else if (adv_i) begin
                case (s)
                    2'b01:   q_reg <= {q_reg[WIDTH-2:0], dsr};
                    2'b10:   q_reg <= {dsl, q_reg[WIDTH-1:1]};
                    2'b11:   q_reg <= d;
                    default: q_reg <= q_reg;
                endcase
            end
        end
    end

    // Clear acts combinationally on the outputs, ahead of the registered clear.
    assign q   = clr_n ? q_reg : '0;
    assign qn  = ~q;
    assign sro = q[WIDTH-1];
    assign slo = q[0];
    assign adv = adv_i & clr_n & (s != 2'b00) & ~reset;

endmodule

// File: tb/tb_x74194_shift.sv
// Directed bench for x74194_shift: edge-detect instance driven from a vector
// table, plus a clock-enable instance exercised by a short hand sequence.
module tb_x74194_shift;

    logic       clk = 1'b0;
    logic       reset, ttl_clk, ttl_b, clr_n, dsr, dsl;
    logic [1:0] s;
    logic [3:0] d;
    logic [3:0] q, qn, q_b, qn_b;
    logic       sro, slo, adv, sro_b, slo_b, adv_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    x74194_shift #(.WIDTH(4), .EDGE_DETECT(1'b1), .RESET_VAL(4'b0011)) dut_a (
        .clk(clk), .reset(reset), .ttl_clk(ttl_clk), .clr_n(clr_n), .s(s),
        .dsr(dsr), .dsl(dsl), .d(d), .q(q), .qn(qn), .sro(sro), .slo(slo), .adv(adv)
    );

    x74194_shift #(.WIDTH(4), .EDGE_DETECT(1'b0), .RESET_VAL(4'b0000)) dut_b (
        .clk(clk), .reset(reset), .ttl_clk(ttl_b), .clr_n(clr_n), .s(s),
        .dsr(dsr), .dsl(dsl), .d(d), .q(q_b), .qn(qn_b), .sro(sro_b), .slo(slo_b), .adv(adv_b)
    );

    typedef struct {
        logic       rst;
        logic       ttl;
        logic       clr;
        logic [1:0] s;
        logic       dsr;
        logic       dsl;
        logic [3:0] d;
        logic       eadv;   // adv before the clk edge
        logic [3:0] epre;   // q before the clk edge
        logic [3:0] epost;  // q after the clk edge
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ttl, input logic clr, input logic [1:0] sm,
                       input logic sr, input logic sl, input logic [3:0] dd,
                       input logic eadv, input logic [3:0] epre, input logic [3:0] epost);
        vec_t v;
        v.rst = rst; v.ttl = ttl; v.clr = clr; v.s = sm; v.dsr = sr; v.dsl = sl; v.d = dd;
        v.eadv = eadv; v.epre = epre; v.epost = epost;
        vecs.push_back(v);
    endtask

    task automatic check_a(input string tag, input int idx, input logic [3:0] e);
        chk({tag, " q"}, idx, q, e);
        chk({tag, " qn"}, idx, qn, ~e);
        chk({tag, " sro"}, idx, {3'b0, sro}, {3'b0, e[3]});
        chk({tag, " slo"}, idx, {3'b0, slo}, {3'b0, e[0]});
    endtask

    initial begin
        reset = 1'b1; ttl_clk = 1'b1; ttl_b = 1'b0; clr_n = 1'b1;
        s = 2'b11; dsr = 1'b0; dsl = 1'b0; d = 4'b1010;

        //  rst ttl clr s     dsr dsl d        adv pre      post
        add(1, 1, 1, 2'b11, 0, 0, 4'b1010, 0, 4'b0011, 4'b0011); // reset with ttl high
        add(0, 1, 1, 2'b11, 0, 0, 4'b1010, 0, 4'b0011, 4'b0011); // held high: no edge
        add(0, 0, 1, 2'b11, 0, 0, 4'b1010, 0, 4'b0011, 4'b0011);
        add(0, 1, 1, 2'b11, 0, 0, 4'b1010, 1, 4'b0011, 4'b1010); // load
        add(0, 1, 1, 2'b11, 0, 0, 4'b0101, 0, 4'b1010, 4'b1010); // adv single pulse
        add(0, 0, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b1010, 4'b1010); // falling edge: nothing
        add(0, 1, 1, 2'b01, 1, 0, 4'b0000, 1, 4'b1010, 4'b0101); // shift right x4
        add(0, 0, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b0101, 4'b0101);
        add(0, 1, 1, 2'b01, 1, 0, 4'b0000, 1, 4'b0101, 4'b1011);
        add(0, 0, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b1011, 4'b1011);
        add(0, 1, 1, 2'b01, 1, 0, 4'b0000, 1, 4'b1011, 4'b0111);
        add(0, 0, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b0111, 4'b0111);
        add(0, 1, 1, 2'b01, 1, 0, 4'b0000, 1, 4'b0111, 4'b1111);
        add(0, 0, 1, 2'b10, 1, 0, 4'b0000, 0, 4'b1111, 4'b1111); // shift left x2
        add(0, 1, 1, 2'b10, 1, 0, 4'b0000, 1, 4'b1111, 4'b0111);
        add(0, 0, 1, 2'b10, 1, 0, 4'b0000, 0, 4'b0111, 4'b0111);
        add(0, 1, 1, 2'b10, 1, 0, 4'b0000, 1, 4'b0111, 4'b0011);
        add(0, 0, 1, 2'b00, 1, 1, 4'b1111, 0, 4'b0011, 4'b0011); // hold: adv stays 0
        add(0, 1, 1, 2'b00, 1, 1, 4'b1111, 0, 4'b0011, 4'b0011);
        add(0, 0, 1, 2'b11, 0, 0, 4'b1010, 0, 4'b0011, 4'b0011);
        add(0, 1, 1, 2'b11, 0, 0, 4'b1010, 1, 4'b0011, 4'b1010);
        add(0, 0, 0, 2'b11, 0, 0, 4'b1010, 0, 4'b0000, 4'b0000); // clear is immediate
        add(0, 1, 0, 2'b11, 0, 0, 4'b1010, 0, 4'b0000, 4'b0000); // edge ignored in clear
        add(0, 0, 1, 2'b11, 0, 0, 4'b1010, 0, 4'b0000, 4'b0000); // q_reg was cleared
        add(0, 1, 1, 2'b11, 0, 0, 4'b1100, 1, 4'b0000, 4'b1100);
        add(0, 0, 1, 2'b01, 0, 0, 4'b0000, 0, 4'b1100, 4'b1100);
        add(1, 1, 1, 2'b01, 0, 0, 4'b0000, 0, 4'b0011, 4'b0011); // reset mid-shift
        add(0, 1, 1, 2'b01, 0, 0, 4'b0000, 0, 4'b0011, 4'b0011);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; ttl_clk = vecs[i].ttl; clr_n = vecs[i].clr;
            s = vecs[i].s; dsr = vecs[i].dsr; dsl = vecs[i].dsl; d = vecs[i].d;
            #1;
            chk("pre adv", i, {3'b0, adv}, {3'b0, vecs[i].eadv});
            check_a("pre", i, vecs[i].epre);
            @(posedge clk);
            #1;
            check_a("post", i, vecs[i].epost);
        end

        // Clock-enable instance: ttl held high shifts on every clk.
        @(negedge clk);
        s = 2'b01; dsr = 1'b1; clr_n = 1'b1; ttl_b = 1'b1;
        #1;
        chk("b adv", 0, {3'b0, adv_b}, 4'b0001);
        @(posedge clk); #1; chk("b q", 1, q_b, 4'b0001);
        chk("b adv", 1, {3'b0, adv_b}, 4'b0001);
        @(posedge clk); #1; chk("b q", 2, q_b, 4'b0011);
        @(posedge clk); #1; chk("b q", 3, q_b, 4'b0111);
        chk("b sro", 3, {3'b0, sro_b}, 4'b0000);
        chk("b slo", 3, {3'b0, slo_b}, 4'b0001);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("b reset q", 4, q_b, 4'b0000);
        chk("b reset qn", 4, qn_b, 4'b1111);
        chk("b reset adv", 4, {3'b0, adv_b}, 4'b0000);
        @(posedge clk); #1; chk("b reset hold q", 5, q_b, 4'b0000);
        @(negedge clk);
        reset = 1'b0; ttl_b = 1'b0;
        @(posedge clk); #1; chk("b disabled q", 6, q_b, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
